pll_ce_gen: RTL and testbench

- Parametrised clock-enable generator. Runs from one master clock, the 112 MHz core clock, and produces NUM_CH phase-aligned clock-enable pulses plus 50%-duty level outputs.
- Replaces fixed PLL output taps with divided enables in a single clock domain.
- Adds run-time reprogramming of per-channel divide ratio and phase through a valid/ready port.
- Adds a lock/relock sequence equivalent to a PLL "locked" output.

---
 rtl/pll_ce_pkg.sv | 20 ++
 rtl/pll_ce_chan.sv | 56 +++++
 rtl/pll_ce_gen.sv | 119 +++++++++++
 tb/tb_pll_ce_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ce_pkg.sv
// rtl/pll_ce_pkg.sv - shared types and helpers for the clock-enable generator
package pll_ce_pkg;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      RUN    = 2'd1,
      RELOCK = 2'd2
   } state_t;

   // Width of an index able to address n items; never narrower than 1 bit.
   function automatic int ch_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // ceil((div+1)/2): number of counts per period that lvl stays high.
   function automatic int half_ceil(input int div);
      return (div / 2) + 1;
   endfunction

endpackage

// File: rtl/pll_ce_chan.sv
// rtl/pll_ce_chan.sv - one divided clock-enable channel
// Ports:
//   clk, rst_n        master clock, asynchronous active-low reset
//   run               channel outputs enabled, counter advances
//   clear             counter forced to 0 (has priority over run)
//   wr                load wr_div / wr_phase
//   wr_div, wr_phase  new divide field and (already clamped) phase
//   ce, lvl           enable pulse and ~50% duty level
module pll_ce_chan
   import pll_ce_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int RST_DIV = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clear,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   output logic             ce,
   output logic             lvl
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] phase_q;
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] thr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= DIV_W'(RST_DIV);
         phase_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (wr) begin
            div_q   <= wr_div;
            phase_q <= wr_phase;
         end
         if (clear) begin
            cnt_q <= '0;
         end else if (run) begin
            cnt_q <= (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
         end
      end
   end

   // Threshold never exceeds 2^(DIV_W-1), so it fits in DIV_W bits.
   always_comb begin
      thr = DIV_W'(half_ceil(int'(div_q)));
      ce  = run & (cnt_q == phase_q);
      lvl = run & (cnt_q < thr);
   end

endmodule

// File: rtl/pll_ce_gen.sv
// rtl/pll_ce_gen.sv - phase-aligned clock-enable generator with lock sequencing
// Ports:
//   refclk, rst_n     master clock, asynchronous active-low reset
//   cfg_valid/ready   reconfiguration handshake, accepted when both high
//   cfg_ch            target channel
//   cfg_div           new divide field (ratio = div+1)
//   cfg_phase         new phase offset in counts, clamped to cfg_div
//   cfg_err           one-cycle pulse after a request to a nonexistent channel
//   ce, lvl           per-channel enable pulses and divided levels
//   locked            outputs valid and phase-aligned
module pll_ce_gen
   import pll_ce_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int RST_DIV     = 1,
   localparam int CH_W       = ch_w(NUM_CH)
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce,
   output logic [NUM_CH-1:0] lvl,
   output logic              locked
);

   localparam int LC_W = ch_w(LOCK_CYCLES);

   state_t            state_q;
   state_t            state_d;
   logic [LC_W-1:0]   lock_q;
   logic [LC_W-1:0]   lock_d;
   logic              err_q;
   logic              err_d;
   logic              accept;
   logic              ch_ok;
   logic              accept_ok;
   logic              clear;
   logic [DIV_W-1:0]  phase_cl;

   assign locked    = (state_q == RUN);
   assign cfg_ready = (state_q == RUN);
   assign cfg_err   = err_q;

   assign accept    = cfg_valid & cfg_ready;
   assign ch_ok     = (int'(cfg_ch) < NUM_CH);
   assign accept_ok = accept & ch_ok;
   assign phase_cl  = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;

   // Counters sit at 0 whenever not locked, and are zeroed on the accepting
   // edge, so every channel starts from 0 in the first RUN cycle.
   assign clear     = ~locked | accept_ok;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT;
         lock_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      err_d   = 1'b0;
      case (state_q)
         WAIT, RELOCK: begin
            if (lock_q == LC_W'(LOCK_CYCLES - 1)) begin
               state_d = RUN;
               lock_d  = '0;
            end else begin
               lock_d  = lock_q + LC_W'(1);
            end
         end
         RUN: begin
            if (accept_ok) begin
               state_d = RELOCK;
            end else if (accept) begin
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = WAIT;
            lock_d  = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr;
      assign wr = accept_ok & (cfg_ch == CH_W'(i));

      pll_ce_chan #(
         .DIV_W   (DIV_W),
         .RST_DIV (RST_DIV)
      ) u_chan (
         .clk      (refclk),
         .rst_n    (rst_n),
         .run      (locked),
         .clear    (clear),
         .wr       (wr),
         .wr_div   (cfg_div),
         .wr_phase (phase_cl),
         .ce       (ce[i]),
         .lvl      (lvl[i])
      );
   end

endmodule

// File: tb/tb_pll_ce_gen.sv
// tb/tb_pll_ce_gen.sv - directed self-checking bench for pll_ce_gen
module tb_pll_ce_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [7:0] cfg_phase;
   logic       cfg_err;
   logic [7:0] ce;
   logic [7:0] lvl;
   logic       locked;

   logic       cfg6_valid;
   logic       cfg6_ready;
   logic [2:0] cfg6_ch;
   logic [7:0] cfg6_div;
   logic [7:0] cfg6_phase;
   logic       cfg6_err;
   logic [5:0] ce6;
   logic [5:0] lvl6;
   logic       locked6;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int div_m [8];
   int ph_m  [8];

   always #5 clk = ~clk;

   pll_ce_gen #(.NUM_CH(8), .DIV_W(8), .LOCK_CYCLES(16), .RST_DIV(1)) u_dut (
      .refclk    (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_err   (cfg_err),
      .ce        (ce),
      .lvl       (lvl),
      .locked    (locked)
   );

   pll_ce_gen #(.NUM_CH(6), .DIV_W(8), .LOCK_CYCLES(16), .RST_DIV(1)) u_dut6 (
      .refclk    (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg6_valid),
      .cfg_ready (cfg6_ready),
      .cfg_ch    (cfg6_ch),
      .cfg_div   (cfg6_div),
      .cfg_phase (cfg6_phase),
      .cfg_err   (cfg6_err),
      .ce        (ce6),
      .lvl       (lvl6),
      .locked    (locked6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         div_m[i] = 1;
         ph_m[i]  = 0;
      end
   endtask

   // k = cycles since RUN entry; ratio N = div+1, pulse where k mod N == phase,
   // level high for the first ceil(N/2) counts of each period.
   function automatic logic [7:0] exp_ce(input int k);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = ((k % (div_m[i] + 1)) == ph_m[i]);
      return v;
   endfunction

   function automatic logic [7:0] exp_lvl(input int k);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = ((k % (div_m[i] + 1)) < ((div_m[i] + 2) / 2));
      return v;
   endfunction

   task automatic check_lock(input int a, input int b);
      for (int c = a; c <= b; c++) begin
         run_to(c);
         chk("lock_locked", 32'(locked), 32'd0);
         chk("lock_ready", 32'(cfg_ready), 32'd0);
         chk("lock_ce", 32'(ce), 32'd0);
         chk("lock_lvl", 32'(lvl), 32'd0);
      end
   endtask

   task automatic check_run(input int a, input int b, input int start);
      for (int c = a; c <= b; c++) begin
         run_to(c);
         chk("run_locked", 32'(locked), 32'd1);
         chk("run_ready", 32'(cfg_ready), 32'd1);
         chk("run_ce", 32'(ce), 32'(exp_ce(c - start)));
         chk("run_lvl", 32'(lvl), 32'(exp_lvl(c - start)));
         chk("run_err", 32'(cfg_err), 32'd0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
      cfg6_valid = 1'b0; cfg6_ch = '0; cfg6_div = '0; cfg6_phase = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_lvl", 32'(lvl), 32'd0);

      // Release: cycle 0 is the cycle ending in the first edge with rst_n high
      rst_n = 1'b1;
      cyc = 0;
      check_lock(0, 15);
      check_run(16, 29, 16);

      // Nonexistent channel on the 6-channel instance
      cfg6_valid = 1'b1; cfg6_ch = 3'd7; cfg6_div = 8'd3; cfg6_phase = 8'd0;
      chk("inv_ready", 32'(cfg6_ready), 32'd1);
      chk("inv_err_before", 32'(cfg6_err), 32'd0);
      check_run(30, 30, 16);
      tick();
      cfg6_valid = 1'b0;
      chk("inv_err_pulse", 32'(cfg6_err), 32'd1);
      chk("inv_locked", 32'(locked6), 32'd1);
      chk("inv_ce_odd", 32'(ce6), 32'd0);
      check_run(31, 31, 16);
      tick();
      chk("inv_err_clear", 32'(cfg6_err), 32'd0);
      chk("inv_ce_even", 32'(ce6), 32'h3f);
      chk("inv_lvl_even", 32'(lvl6), 32'h3f);
      chk("inv_locked2", 32'(locked6), 32'd1);
      check_run(32, 40, 16);

      // ch3 div=3 phase=2 accepted at 40 -> relock 41..56, RUN at 57
      cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = 8'd3; cfg_phase = 8'd2;
      tick();
      cfg_valid = 1'b0;
      div_m[3] = 3; ph_m[3] = 2;
      check_lock(41, 56);
      check_run(57, 72, 57);

      // ch1 div=0 accepted at 72; ch5 held valid through relock, accepted at 89
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0; cfg_phase = 8'd0;
      tick();
      cfg_ch = 3'd5; cfg_div = 8'd2; cfg_phase = 8'd5;
      div_m[1] = 0; ph_m[1] = 0;
      check_lock(73, 88);
      check_run(89, 89, 89);
      tick();
      cfg_valid = 1'b0;
      div_m[5] = 2; ph_m[5] = 2;
      check_lock(90, 105);
      check_run(106, 118, 106);

      // ch0 reprogrammed at 118, then async reset mid-relock at 126
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd1; cfg_phase = 8'd1;
      tick();
      cfg_valid = 1'b0;
      check_lock(119, 126);
      rst_n = 1'b0;
      #1;
      chk("arst_relock_locked", 32'(locked), 32'd0);
      chk("arst_relock_ready", 32'(cfg_ready), 32'd0);
      chk("arst_relock_ce", 32'(ce), 32'd0);
      chk("arst_relock_lvl", 32'(lvl), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      cyc = 0;
      model_reset();
      check_lock(0, 15);
      check_run(16, 24, 16);

      // Async reset during RUN: outputs drop before the next edge
      rst_n = 1'b0;
      #1;
      chk("arst_run_locked", 32'(locked), 32'd0);
      chk("arst_run_ready", 32'(cfg_ready), 32'd0);
      chk("arst_run_ce", 32'(ce), 32'd0);
      chk("arst_run_lvl", 32'(lvl), 32'd0);
      chk("arst_run_ce6", 32'(ce6), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      cyc = 0;
      check_lock(0, 15);
      check_run(16, 20, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
